// File: rtl/ripemd160_msg_padder.sv
// RIPEMD-160 message padder: packs a 32-bit byte stream into 512-bit blocks
// with 0x80 / zero fill / LE64 bit length; valid/ready on both sides.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input word handshake
//   in_data/in_last         word (first byte in [31:24]) and end-of-message
//   in_bytes                valid bytes in the last word (0..4)
//   o_valid/o_ready         block handshake
//   o_block/o_last          512-bit block and final-block flag

module ripemd160_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [511:0] o_block,
  output logic         o_last
);

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_EMIT,
    S_LEN
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       buf_q [64];
  logic [7:0]       buf_d [64];
  logic [6:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend80_q, pend80_d;
  logic             pendlen_q, pendlen_d;
  logic             alive_q;

  logic [2:0]       n;
  logic             fire;
  logic [63:0]      len64;

  assign fire  = in_valid & in_ready;
  // Short or oversized counts only matter on the final word.
  assign n     = (in_last && in_bytes <= 3'd4) ? in_bytes : 3'd4;
  assign len64 = 64'({cnt_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      ptr_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      pend80_q  <= 1'b0;
      pendlen_q <= 1'b0;
      alive_q   <= 1'b0;
      for (int i = 0; i < 64; i++)
        buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      pend80_q  <= pend80_d;
      pendlen_q <= pendlen_d;
      alive_q   <= 1'b1;
      for (int i = 0; i < 64; i++)
        buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    pend80_d  = pend80_q;
    pendlen_d = pendlen_q;
    unique case (state_q)
      S_FILL: begin
        if (fire) begin
          for (int k = 0; k < 4; k++)
            if (3'(k) < n)
              buf_d[ptr_q[5:0] + 6'(k)] = in_data[8*(3-k) +: 8];
          ptr_d = ptr_q + 7'(n);
          cnt_d = cnt_q + CNT_W'(n);
          if (in_last) begin
            state_d = S_PAD;
          end else if (ptr_d == 7'd64) begin
            state_d = S_EMIT;
            last_d  = 1'b0;
          end
        end
      end
      S_PAD: begin
        state_d = S_EMIT;
        if (ptr_q[6]) begin
          // Exactly full: the 0x80 and length go in a trailer block.
          pend80_d  = 1'b1;
          pendlen_d = 1'b1;
          last_d    = 1'b0;
        end else begin
          for (int j = 0; j < 64; j++) begin
            if (7'(j) == ptr_q)
              buf_d[j] = 8'h80;
            else if (7'(j) > ptr_q)
              buf_d[j] = 8'h00;
          end
          if (ptr_q <= 7'd55) begin
            for (int j = 0; j < 8; j++)
              buf_d[56+j] = len64[8*j +: 8];
            last_d = 1'b1;
          end else begin
            // No room for the length field.
            pendlen_d = 1'b1;
            last_d    = 1'b0;
          end
        end
      end
      S_LEN: begin
        for (int j = 0; j < 64; j++)
          buf_d[j] = 8'h00;
        if (pend80_q)
          buf_d[0] = 8'h80;
        for (int j = 0; j < 8; j++)
          buf_d[56+j] = len64[8*j +: 8];
        pend80_d  = 1'b0;
        pendlen_d = 1'b0;
        last_d    = 1'b1;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (o_ready) begin
          for (int j = 0; j < 64; j++)
            buf_d[j] = 8'h00;
          ptr_d  = '0;
          last_d = 1'b0;
          if (last_q) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else if (pendlen_q) begin
            state_d = S_LEN;
          end else begin
            state_d = S_FILL;
          end
        end
      end
    endcase
  end

  always_comb begin
    in_ready = alive_q & (state_q == S_FILL);
    o_valid  = (state_q == S_EMIT);
    o_last   = last_q & (state_q == S_EMIT);
    o_block  = '0;
    for (int i = 0; i < 16; i++)
      o_block[511-32*i -: 32] = {buf_q[4*i+3], buf_q[4*i+2],
                                 buf_q[4*i+1], buf_q[4*i]};
  end

endmodule
